// File: rtl/hsci_axil_regif_bridge.sv
// AXI4-Lite slave bridging host register accesses onto the HSCI master
// register-file port; one access in flight at a time.
module hsci_axil_regif_bridge #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      clk,
  input  logic                      srstn,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0]     read_data,
  output logic                      wr_stb,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data
);
  typedef enum logic [1:0] {IDLE, WR_RESP, RD_WAIT, RD_RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                    state, state_d;
  logic                      aw_held, w_held, aw_held_d, w_held_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;
  logic                      last_wr, rd_oor;
  logic [2:0]                rd_cnt;
  logic                      aw_hs, w_hs, ar_hs;
  logic                      write_rdy, write_incoming, write_first;
  logic                      wr_ok, ar_oor, issue_wr, raise_ar;

  assign aw_hs          = s_axi_awvalid & s_axi_awready;
  assign w_hs           = s_axi_wvalid & s_axi_wready;
  assign ar_hs          = s_axi_arvalid & s_axi_arready;
  assign write_rdy      = aw_held & w_held;
  assign write_incoming = (aw_held | aw_hs) & (w_held | w_hs);
  assign write_first    = ~last_wr;
  assign wr_ok          = ((awaddr_q >> (ADDR_WIDTH + 2)) == '0) && (&wstrb_q);
  assign ar_oor         = (s_axi_araddr >> (ADDR_WIDTH + 2)) != '0;

  assign wr_stb  = issue_wr & wr_ok;
  assign wr_addr = awaddr_q[ADDR_WIDTH+1:2];
  assign wr_data = wdata_q;

  // A write completing in the same cycle as arvalid still counts for
  // arbitration, so arready is held back when it is the write's turn.
  always_comb begin
    state_d  = state;
    issue_wr = 1'b0;
    raise_ar = 1'b0;
    case (state)
      IDLE: begin
        if (ar_hs) begin
          state_d = RD_WAIT;
        end else if (write_rdy && !s_axi_arready && (!s_axi_arvalid || write_first)) begin
          issue_wr = 1'b1;
          state_d  = WR_RESP;
        end else if (s_axi_arvalid && !s_axi_arready && !(write_incoming && write_first)) begin
          raise_ar = 1'b1;
        end
      end
      WR_RESP: if (s_axi_bready)  state_d = IDLE;
      RD_WAIT: if (rd_cnt == '0)  state_d = RD_RESP;
      RD_RESP: if (s_axi_rready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    aw_held_d = issue_wr ? 1'b0 : (aw_held | aw_hs);
    w_held_d  = issue_wr ? 1'b0 : (w_held | w_hs);
  end

  always_ff @(posedge clk) begin
    if (!srstn) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      last_wr       <= 1'b0;
      rd_oor        <= 1'b0;
      rd_cnt        <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= '0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      rd_addr       <= '0;
    end else begin
      aw_held       <= aw_held_d;
      w_held        <= w_held_d;
      s_axi_awready <= (state_d == IDLE) && !aw_held_d;
      s_axi_wready  <= (state_d == IDLE) && !w_held_d;
      s_axi_arready <= raise_ar;
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (ar_hs) begin
        rd_addr <= s_axi_araddr[ADDR_WIDTH+1:2];
        rd_oor  <= ar_oor;
        rd_cnt  <= 3'(RD_LATENCY);
        last_wr <= 1'b0;
      end
      if (issue_wr) begin
        last_wr      <= 1'b1;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (state == WR_RESP && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      if (state == RD_WAIT) begin
        if (rd_cnt == '0) begin
          s_axi_rvalid <= 1'b1;
          s_axi_rdata  <= rd_oor ? '0 : read_data;
          s_axi_rresp  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
        end else begin
          rd_cnt <= rd_cnt - 3'd1;
        end
      end
      if (state == RD_RESP && s_axi_rready) s_axi_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hsci_axil_regif_bridge.sv
// Scoreboard bench for hsci_axil_regif_bridge: expected writes/responses are
// queued at stimulus time and matched against events seen by the monitor.
module tb_hsci_axil_regif_bridge;
  logic        clk = 1'b0;
  logic        srstn = 1'b0;
  logic [15:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [15:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;
  logic [9:0]  rd_addr;
  logic [31:0] read_data = '0;
  logic        wr_stb;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  always #5 clk = ~clk;

  hsci_axil_regif_bridge #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .AXI_ADDR_WIDTH(16), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .srstn(srstn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .rd_addr(rd_addr),
    .read_data(read_data), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  typedef struct { int cyc; logic [9:0] addr; logic [31:0] data; } wr_ev_t;
  typedef struct { int cyc; logic [1:0] resp; } b_ev_t;
  typedef struct { int cyc; logic [31:0] data; logic [1:0] resp; } r_ev_t;

  wr_ev_t obs_wr[$], exp_wr[$];
  b_ev_t  obs_b[$],  exp_b[$];
  r_ev_t  obs_r[$],  exp_r[$];
  int     obs_aw[$], obs_w[$], obs_ar[$];
  string  order = "";
  int     cyc = 0;
  int     n_bvalid = 0, n_rvalid = 0;
  int     n_checks = 0, n_fail = 0;

  // Register-file model: one cycle from rd_addr to read_data.
  function automatic logic [31:0] rf_val(input logic [9:0] a);
    return (a == 10'd4) ? 32'h12345678 : (32'hA5000000 | 32'(a));
  endfunction

  always @(posedge clk) read_data <= rf_val(rd_addr);
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_stb) begin
      obs_wr.push_back('{cyc, wr_addr, wr_data});
      order = {order, "W"};
    end
    if (s_axi_awvalid && s_axi_awready) obs_aw.push_back(cyc);
    if (s_axi_wvalid && s_axi_wready) obs_w.push_back(cyc);
    if (s_axi_arvalid && s_axi_arready) begin
      obs_ar.push_back(cyc);
      order = {order, "R"};
    end
    if (s_axi_bvalid && s_axi_bready) obs_b.push_back('{cyc, s_axi_bresp});
    if (s_axi_rvalid && s_axi_rready) obs_r.push_back('{cyc, s_axi_rdata, s_axi_rresp});
    if (s_axi_bvalid) n_bvalid++;
    if (s_axi_rvalid) n_rvalid++;
  end

  function automatic logic [93:0] outs();
    return {s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
            s_axi_rdata, s_axi_rresp, s_axi_rvalid, rd_addr, wr_stb, wr_addr, wr_data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    obs_wr.delete(); exp_wr.delete(); obs_b.delete(); exp_b.delete();
    obs_r.delete(); exp_r.delete(); obs_aw.delete(); obs_w.delete(); obs_ar.delete();
    order = "";
  endtask

  task automatic timeout(input string what);
    n_checks++; n_fail++;
    $display("FAIL %s: handshake not seen, required within 200 cycles", what);
  endtask

  task automatic send_aw(input logic [15:0] a);
    tick();
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axi_awready) begin tick(); s_axi_awvalid = 1'b0; return; end
    end
    s_axi_awvalid = 1'b0;
    timeout("aw_accept");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    tick();
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axi_wready) begin tick(); s_axi_wvalid = 1'b0; return; end
    end
    s_axi_wvalid = 1'b0;
    timeout("w_accept");
  endtask

  task automatic send_ar(input logic [15:0] a);
    tick();
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axi_arready) begin tick(); s_axi_arvalid = 1'b0; return; end
    end
    s_axi_arvalid = 1'b0;
    timeout("ar_accept");
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic wait_b(input int n);
    for (int i = 0; i < 200; i++) begin
      if (obs_b.size() >= n) return;
      @(negedge clk);
    end
    timeout("b_handshake");
  endtask

  task automatic wait_r(input int n);
    for (int i = 0; i < 200; i++) begin
      if (obs_r.size() >= n) return;
      @(negedge clk);
    end
    timeout("r_handshake");
  endtask

  task automatic wait_bvalid();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axi_bvalid) return;
    end
    timeout("bvalid_rise");
  endtask

  task automatic wait_rvalid();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axi_rvalid) return;
    end
    timeout("rvalid_rise");
  endtask

  task automatic test_reset();
    srstn = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if (outs() !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", outs()); end
    tick();
    srstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({s_axi_awready, s_axi_wready} !== 2'b00) begin
      n_fail++; $display("FAIL ready_early: got %b required 00", {s_axi_awready, s_axi_wready});
    end
    @(negedge clk);
    n_checks++;
    if ({s_axi_awready, s_axi_wready} !== 2'b11) begin
      n_fail++; $display("FAIL ready_after_reset: got %b required 11", {s_axi_awready, s_axi_wready});
    end
  endtask

  task automatic test_write_basic();
    wr_ev_t o, e;
    b_ev_t  ob, eb;
    clear_sb();
    exp_wr.push_back('{0, 10'd4, 32'hDEADBEEF});
    exp_b.push_back('{0, 2'b00});
    do_write(16'h0010, 32'hDEADBEEF, 4'hF);
    wait_b(1);
    n_checks++;
    if (obs_wr.size() !== 1) begin n_fail++; $display("FAIL wr_stb_count: got %0d required 1", obs_wr.size()); end
    n_checks++;
    if (obs_aw.size() != 1 || obs_w.size() != 1 || obs_aw[0] !== obs_w[0]) begin
      n_fail++; $display("FAIL aw_w_same_cycle: got %0d/%0d accepts required one each, same cycle", obs_aw.size(), obs_w.size());
    end
    if (obs_wr.size() > 0 && obs_b.size() > 0 && obs_aw.size() > 0) begin
      o = obs_wr.pop_front(); e = exp_wr.pop_front();
      ob = obs_b.pop_front(); eb = exp_b.pop_front();
      n_checks++;
      if (o.addr !== e.addr) begin n_fail++; $display("FAIL wr_addr: got %h required %h", o.addr, e.addr); end
      n_checks++;
      if (o.data !== e.data) begin n_fail++; $display("FAIL wr_data: got %h required %h", o.data, e.data); end
      n_checks++;
      if (o.cyc !== obs_aw[0] + 1) begin n_fail++; $display("FAIL wr_stb_latency: got %0d required %0d", o.cyc, obs_aw[0] + 1); end
      n_checks++;
      if (ob.resp !== eb.resp) begin n_fail++; $display("FAIL bresp_okay: got %b required %b", ob.resp, eb.resp); end
      n_checks++;
      if (ob.cyc !== obs_aw[0] + 2) begin n_fail++; $display("FAIL bvalid_latency: got %0d required %0d", ob.cyc, obs_aw[0] + 2); end
    end
  endtask

  task automatic test_read_basic();
    r_ev_t o, e;
    clear_sb();
    exp_r.push_back('{0, 32'h12345678, 2'b00});
    send_ar(16'h0010);
    @(negedge clk);
    n_checks++;
    if (rd_addr !== 10'd4) begin n_fail++; $display("FAIL rd_addr: got %h required 004", rd_addr); end
    wait_r(1);
    if (obs_r.size() > 0 && obs_ar.size() > 0) begin
      o = obs_r.pop_front(); e = exp_r.pop_front();
      n_checks++;
      if (o.data !== e.data) begin n_fail++; $display("FAIL rdata: got %h required %h", o.data, e.data); end
      n_checks++;
      if (o.resp !== e.resp) begin n_fail++; $display("FAIL rresp_okay: got %b required %b", o.resp, e.resp); end
      n_checks++;
      if (o.cyc !== obs_ar[0] + 3) begin n_fail++; $display("FAIL rvalid_latency: got %0d required %0d", o.cyc, obs_ar[0] + 3); end
    end
  endtask

  task automatic test_backpressure();
    wr_ev_t o;
    r_ev_t  orr;
    bit     ok;
    clear_sb();
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    send_w(32'hCAFEF00D, 4'hF);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (wr_stb || !s_axi_awready || s_axi_wready) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL w_only_wait: got stb/ready activity required none (awready=1, wready=0)"); end
    send_aw(16'h0020);
    wait_bvalid();
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || s_axi_awready || s_axi_wready || s_axi_arready) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL b_stable: got bvalid=%b bresp=%b required 1/00 held", s_axi_bvalid, s_axi_bresp); end
    s_axi_bready = 1'b1;
    wait_b(1);
    n_checks++;
    if (obs_wr.size() !== 1 || obs_aw.size() !== 1) begin
      n_fail++; $display("FAIL late_aw_stb_count: got %0d required 1", obs_wr.size());
    end else begin
      o = obs_wr.pop_front();
      n_checks++;
      if ({o.addr, o.data} !== {10'd8, 32'hCAFEF00D} || o.cyc !== obs_aw[0] + 1) begin
        n_fail++; $display("FAIL late_aw_write: got %h/%h@%0d required 008/cafef00d@%0d", o.addr, o.data, o.cyc, obs_aw[0] + 1);
      end
    end
    send_ar(16'h0024);
    wait_rvalid();
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hA5000009 || s_axi_rresp !== 2'b00 ||
          s_axi_awready || s_axi_wready || s_axi_arready) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL r_stable: got rdata=%h required a5000009 held", s_axi_rdata); end
    s_axi_rready = 1'b1;
    wait_r(1);
    if (obs_r.size() > 0) begin
      orr = obs_r.pop_front();
      n_checks++;
      if (orr.data !== 32'hA5000009) begin n_fail++; $display("FAIL r_after_stall: got %h required a5000009", orr.data); end
    end
  endtask

  task automatic test_errors();
    r_ev_t o;
    clear_sb();
    exp_b.push_back('{0, 2'b10});
    exp_b.push_back('{0, 2'b10});
    exp_r.push_back('{0, 32'h0, 2'b10});
    do_write(16'h1000, 32'h11111111, 4'hF);
    wait_b(1);
    do_write(16'h0010, 32'h22222222, 4'h3);
    wait_b(2);
    send_ar(16'h1000);
    wait_r(1);
    n_checks++;
    if (obs_wr.size() !== 0) begin n_fail++; $display("FAIL err_no_stb: got %0d strobes required 0", obs_wr.size()); end
    for (int i = 0; i < 2; i++) begin
      if (obs_b.size() > 0) begin
        n_checks++;
        if (obs_b[0].resp !== exp_b[0].resp) begin
          n_fail++; $display("FAIL err_bresp%0d: got %b required %b", i, obs_b[0].resp, exp_b[0].resp);
        end
        void'(obs_b.pop_front()); void'(exp_b.pop_front());
      end
    end
    if (obs_r.size() > 0) begin
      o = obs_r.pop_front();
      n_checks++;
      if ({o.data, o.resp} !== {exp_r[0].data, exp_r[0].resp}) begin
        n_fail++; $display("FAIL err_read: got %h/%b required %h/%b", o.data, o.resp, exp_r[0].data, exp_r[0].resp);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    for (int k = 0; k < 3; k++) begin
      exp_wr.push_back('{0, 10'(16 + k), 32'h0B0B0000 + 32'(k)});
      do_write(16'h0040 + 16'(4 * k), 32'h0B0B0000 + 32'(k), 4'hF);
    end
    wait_b(3);
    n_checks++;
    if (obs_aw.size() !== 3 || obs_wr.size() !== 3 || obs_b.size() !== 3) begin
      n_fail++; $display("FAIL b2b_counts: got %0d/%0d/%0d required 3/3/3", obs_aw.size(), obs_wr.size(), obs_b.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({obs_wr[k].addr, obs_wr[k].data} !== {exp_wr[k].addr, exp_wr[k].data} || obs_b[k].cyc !== obs_aw[k] + 2) begin
          n_fail++; $display("FAIL b2b_write%0d: got %h/%h b@%0d required %h/%h b@%0d", k, obs_wr[k].addr,
                             obs_wr[k].data, obs_b[k].cyc, exp_wr[k].addr, exp_wr[k].data, obs_aw[k] + 2);
        end
        if (k > 0) begin
          n_checks++;
          if (obs_aw[k] - obs_aw[k-1] !== 3) begin
            n_fail++; $display("FAIL b2b_spacing%0d: got %0d cycles required 3", k, obs_aw[k] - obs_aw[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_arbitration();
    srstn = 1'b0;
    tick(); tick();
    srstn = 1'b1;
    @(negedge clk); @(negedge clk);
    clear_sb();
    fork
      begin
        exp_wr.push_back('{0, 10'd20, 32'hA1A1A1A1});
        do_write(16'h0050, 32'hA1A1A1A1, 4'hF);
        wait_b(1);
        exp_wr.push_back('{0, 10'd21, 32'hB2B2B2B2});
        do_write(16'h0054, 32'hB2B2B2B2, 4'hF);
        wait_b(2);
      end
      begin
        exp_r.push_back('{0, 32'hA5000002, 2'b00});
        send_ar(16'h0008);
        wait_r(1);
        exp_r.push_back('{0, 32'hA5000003, 2'b00});
        send_ar(16'h000C);
        wait_r(2);
      end
    join
    n_checks++;
    if (order != "WRWR") begin n_fail++; $display("FAIL arb_order: got %s required WRWR", order); end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_wr.size() <= k || {obs_wr[k].addr, obs_wr[k].data} !== {exp_wr[k].addr, exp_wr[k].data} ||
          obs_b.size() <= k || obs_b[k].resp !== 2'b00) begin
        n_fail++; $display("FAIL arb_write%0d: got mismatching strobe or bresp, required %h/%h OKAY", k, exp_wr[k].addr, exp_wr[k].data);
      end
      n_checks++;
      if (obs_r.size() <= k || {obs_r[k].data, obs_r[k].resp} !== {exp_r[k].data, exp_r[k].resp}) begin
        n_fail++; $display("FAIL arb_read%0d: got wrong or missing R, required %h/%b", k, exp_r[k].data, exp_r[k].resp);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    send_ar(16'h0010);
    srstn = 1'b0;
    tick();
    srstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs() !== '0) begin n_fail++; $display("FAIL rd_wait_reset: got %h required 0", outs()); end
    n_rvalid = 0;
    @(negedge clk);
    n_checks++;
    if ({s_axi_awready, s_axi_wready} !== 2'b11) begin
      n_fail++; $display("FAIL rd_reset_ready: got %b required 11", {s_axi_awready, s_axi_wready});
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (n_rvalid !== 0 || obs_r.size() !== 0) begin n_fail++; $display("FAIL late_rvalid: got %0d cycles required 0", n_rvalid); end

    s_axi_bready = 1'b0;
    do_write(16'h0030, 32'h5A5A5A5A, 4'hF);
    wait_bvalid();
    srstn = 1'b0;
    tick();
    srstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs() !== '0) begin n_fail++; $display("FAIL wr_resp_reset: got %h required 0", outs()); end
    n_bvalid = 0;
    @(negedge clk);
    n_checks++;
    if ({s_axi_awready, s_axi_wready} !== 2'b11) begin
      n_fail++; $display("FAIL wr_reset_ready: got %b required 11", {s_axi_awready, s_axi_wready});
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (n_bvalid !== 0) begin n_fail++; $display("FAIL late_bvalid: got %0d cycles required 0", n_bvalid); end
    s_axi_bready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_backpressure();
    test_errors();
    test_back_to_back();
    test_arbitration();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hsci_axil_regif_bridge.md
Name: hsci_axil_regif_bridge

Overview:
- AXI4-Lite slave that converts host register accesses into the simple register-file port of the HSCI master control logic: rd_addr/read_data, and wr_stb/wr_addr/wr_data.
- Sits directly upstream of the HSCI master register logic, between the processor interconnect and the register map.
- Serialises reads and writes: one register access in flight at a time.
- Returns SLVERR for out-of-range addresses and for partial-strobe writes.

Parameters:
- ADDR_WIDTH, 10, register-file word address width.
- DATA_WIDTH, 32, data width; only 32 is supported.
- AXI_ADDR_WIDTH, 16, AXI byte address width; must be at least ADDR_WIDTH+2.
- RD_LATENCY, 1, clk cycles from rd_addr change to valid read_data (1..7).

Ports:
- clk  in  1  single clock for all logic.
- srstn  in  1  synchronous reset, active-low.
- s_axi_awaddr  in  AXI_ADDR_WIDTH  write byte address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  DATA_WIDTH/8  write byte strobes.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR).
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  AXI_ADDR_WIDTH  read byte address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- rd_addr  out  ADDR_WIDTH  register-file read word address.
- read_data  in  DATA_WIDTH  register-file read data.
- wr_stb  out  1  single-cycle write strobe.
- wr_addr  out  ADDR_WIDTH  write word address.
- wr_data  out  DATA_WIDTH  write data.

Behaviour:
- Reset (srstn=0 sampled on a clk edge): every output is driven to 0, FSM goes to IDLE, and the AW/W holding flags clear.
  - Ready outputs are registered; they rise in the first cycle after srstn returns high.
  - Reset during any transaction abandons it; no wr_stb is issued and no late B/R response is produced.
- Address mapping: word address = byte address[ADDR_WIDTH+1:2]; byte address bits [1:0] are ignored.
  - An address is out of range if any bit above ADDR_WIDTH+1 is set.
- AW and W are accepted independently into one-deep holding registers.
  - s_axi_awready = IDLE and AW not held; s_axi_wready = IDLE and W not held.
  - Both may be accepted in the same cycle.
- FSM states: IDLE, WR_RESP, RD_WAIT, RD_RESP.
- IDLE to write (AW and W both held, including the same-cycle case):
  - If in range and wstrb is all ones: wr_stb=1 for exactly one cycle, with wr_addr/wr_data valid in that cycle, then go to WR_RESP with bresp=OKAY.
  - Otherwise: no wr_stb, go to WR_RESP with bresp=SLVERR.
  - The holding flags clear.
- IDLE to read: when s_axi_arvalid is high and no write is ready to issue, s_axi_arready pulses for one cycle.
  - rd_addr is registered from araddr, the wait counter loads RD_LATENCY, and the FSM goes to RD_WAIT.
  - rd_addr holds its value until the next read.
- Arbitration when a complete write and arvalid are both present in IDLE: the type not granted last goes first (alternating); after reset, write goes first.
- RD_WAIT: count down; at zero, capture read_data into s_axi_rdata and go to RD_RESP with rvalid=1.
  - An out-of-range read returns rdata=0 and rresp=SLVERR.
- WR_RESP: bvalid held high until bready; return to IDLE on the handshake cycle.
- RD_RESP: rvalid, rdata and rresp held stable until rready; return to IDLE on the handshake cycle.
- Latency, write: AW and W accepted in cycle N → wr_stb in N+1 → bvalid in N+2.
- Latency, read (RD_LATENCY=1): AR accepted in cycle N → rd_addr in N+1 → rvalid in N+3. Each extra latency cycle adds one.
- Back-to-back: minimum 3 cycles per write (bready held high); the next AW/W is accepted the cycle after the B handshake.
- Only one transaction is outstanding at any time; no ready output is asserted while the bridge is outside IDLE.

Test Plan:
- Write 0xDEADBEEF to byte address 0x0010 with wstrb=F → single wr_stb with wr_addr=4, wr_data=0xDEADBEEF; bvalid 2 cycles after accept, bresp=00.
- Read 0x0010 with a register-file model returning 0x12345678 (RD_LATENCY=1) → rd_addr=4; rvalid in N+3, rdata=0x12345678, rresp=00.
- W presented 5 cycles before AW, then rready/bready held low 4 cycles → no wr_stb until AW arrives; B/R outputs held stable throughout backpressure.
- Write to byte address 0x1000 (bit 12 set) → no wr_stb, bresp=10. Write with wstrb=0x3 → no wr_stb, bresp=10. Read of 0x1000 → rdata=0, rresp=10.
- arvalid and a complete write asserted together for 4 back-to-back transactions → order W, R, W, R; each returns the correct response.
- srstn pulled low during RD_WAIT and separately during WR_RESP → all outputs 0 the next cycle, no late rvalid/bvalid, readies high 1 cycle after reset release.
